// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush, and control fields forced to zero on every bubble.
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                in_ready_reg, in_ready_next;
  logic [CTRL_W-1:0]   h_ctrl_reg, h_ctrl_next;
  logic [DATA_W-1:0]   h_data_reg, h_data_next;
  logic [CTRL_W-1:0]   s_ctrl_reg, s_ctrl_next;
  logic [DATA_W-1:0]   s_data_reg, s_data_next;

  logic accept;
  logic take;

  assign accept = in_valid && in_ready_reg;
  assign take   = (state_reg != EMPTY) && out_ready;

  always_comb begin
    state_next  = state_reg;
    h_ctrl_next = h_ctrl_reg;
    h_data_next = h_data_reg;
    s_ctrl_next = s_ctrl_reg;
    s_data_next = s_data_reg;

    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next  = ONE;
          h_ctrl_next = in_ctrl;
          h_data_next = in_data;
        end
      end
      ONE: begin
        if (accept && take) begin
          h_ctrl_next = in_ctrl;
          h_data_next = in_data;
        end else if (accept) begin
          state_next  = FULL;
          s_ctrl_next = in_ctrl;
          s_data_next = in_data;
        end else if (take) begin
          // Head becomes a bubble: its control bits must not linger.
          state_next  = EMPTY;
          h_ctrl_next = '0;
        end
      end
      FULL: begin
        if (take) begin
          state_next  = ONE;
          h_ctrl_next = s_ctrl_reg;
          h_data_next = s_data_reg;
          s_ctrl_next = '0;
        end
      end
      default: begin
        state_next  = EMPTY;
        h_ctrl_next = '0;
        s_ctrl_next = '0;
      end
    endcase

    // Flush discards everything, including a same-cycle accept; payload may stay stale.
    if (flush) begin
      state_next  = EMPTY;
      h_ctrl_next = '0;
      s_ctrl_next = '0;
    end

    in_ready_next = (state_next != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b0;
      h_ctrl_reg   <= '0;
      h_data_reg   <= '0;
      s_ctrl_reg   <= '0;
      s_data_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= in_ready_next;
      h_ctrl_reg   <= h_ctrl_next;
      h_data_reg   <= h_data_next;
      s_ctrl_reg   <= s_ctrl_next;
      s_data_reg   <= s_data_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != EMPTY);
  assign out_ctrl  = h_ctrl_reg;
  assign out_data  = h_data_reg;
  assign occupancy = state_reg;

endmodule
